// File: rtl/fpdiv_issue.sv
// fpdiv_issue: issue/response wrapper around a multi-cycle FP32 divider core.
//
// Accepts one operation at a time, launches it on the core with a one-cycle
// core_start pulse, waits for core_done, and queues the quotient in a small
// response FIFO. At most one operation is ever outstanding.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_op, req_round_mode          op code and rounding mode (passed to core)
//   req_a, req_b                    dividend / divisor (IEEE single)
//   core_start                      one-cycle launch pulse
//   core_op/core_round_mode/        operands latched at acceptance, held
//   core_a/core_b                   until the next acceptance
//   core_done, core_result          core completion pulse and quotient
//   rsp_valid/rsp_ready             response FIFO head handshake
//   rsp_result, rsp_op, rsp_timeout head entry fields
//
// Build option: define FPDIV_TIMEOUT_EN to enable the WAIT timeout. When the
// core stays silent for TIMEOUT_CYCLES cycles a quiet-NaN response with
// rsp_timeout=1 is queued instead. Without it, rsp_timeout is constant 0.
module fpdiv_issue #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned RSP_DEPTH      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_round_mode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        core_start,
  output logic [1:0]  core_op,
  output logic        core_round_mode,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic        core_done,
  input  logic [31:0] core_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [1:0]  rsp_op,
  output logic        rsp_timeout
);

  localparam int unsigned PtrW       = $clog2(RSP_DEPTH);
  localparam int unsigned CntW       = PtrW + 1;
  localparam logic [31:0] TimeoutNan = 32'h7FC0_0000;

  typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

  state_e state_q, state_d;

  logic        accept;
  logic        push;
  logic        pop;
  logic        timeout_hit;
  logic [31:0] push_result;

  logic [1:0]  core_op_q;
  logic        core_rm_q;
  logic [31:0] core_a_q;
  logic [31:0] core_b_q;

  logic [31:0]     fifo_result_q [RSP_DEPTH];
  logic [1:0]      fifo_op_q     [RSP_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StLaunch;
      StLaunch: state_d = StWait;
      StWait:   if (core_done || timeout_hit) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // No pending entry exists in IDLE, so the FIFO count alone gates acceptance.
  always_comb begin
    req_ready  = 1'b0;
    core_start = 1'b0;
    push       = 1'b0;
    unique case (state_q)
      StIdle:   req_ready  = (count_q < CntW'(RSP_DEPTH));
      StLaunch: core_start = 1'b1;
      StWait:   push       = core_done || timeout_hit;
      default:  ;
    endcase
  end

  assign accept      = req_valid && req_ready;
  assign push_result = timeout_hit ? TimeoutNan : core_result;

  // ---------------------------------------------------------- operands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_op_q <= '0;
      core_rm_q <= 1'b0;
      core_a_q  <= '0;
      core_b_q  <= '0;
    end else if (accept) begin
      core_op_q <= req_op;
      core_rm_q <= req_round_mode;
      core_a_q  <= req_a;
      core_b_q  <= req_b;
    end
  end

  assign core_op         = core_op_q;
  assign core_round_mode = core_rm_q;
  assign core_a          = core_a_q;
  assign core_b          = core_b_q;

  // ----------------------------------------------------------- timeout
`ifdef FPDIV_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmrW-1:0] timer_q;
  logic            fifo_to_q [RSP_DEPTH];

  // Cleared during LAUNCH so it reads 0 on the first WAIT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else if (state_q == StLaunch) begin
      timer_q <= '0;
    end else if (state_q == StWait) begin
      timer_q <= timer_q + TmrW'(1);
    end
  end

  // A real completion in the last cycle wins over the timeout.
  assign timeout_hit = (state_q == StWait) && !core_done &&
                       (timer_q == TmrW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (push) fifo_to_q[wr_ptr_q] <= timeout_hit;
  end

  assign rsp_timeout = fifo_to_q[rd_ptr_q];
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign rsp_timeout        = 1'b0;
`endif

  // ------------------------------------------------------ response FIFO
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid && rsp_ready;

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_result_q[wr_ptr_q] <= push_result;
      fifo_op_q[wr_ptr_q]     <= core_op_q;
    end
  end

  assign rsp_result = fifo_result_q[rd_ptr_q];
  assign rsp_op     = fifo_op_q[rd_ptr_q];

endmodule
